// File: rtl/radix2_divider.sv
// Sequential restoring radix-2 divider returning floor(dividend * 2^FRACTION_WIDTH / divisor)
// over AXI-Stream style handshakes. One quotient bit per clock, fixed latency.
//
// state | meaning
// IDLE  | both operand channels ready, waiting for dividend and divisor together
// CALC  | one restoring step per edge, down-counter from QW-1 to 0
// DONE  | result presented, held until the downstream handshake completes
module radix2_divider #(
  parameter int DIVIDEND_WIDTH = 13,
  parameter int DIVISOR_WIDTH  = 13,
  parameter int FRACTION_WIDTH = 8,
  parameter int DOUT_WIDTH     = 24
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      s_axis_dividend_tvalid,
  output logic                      s_axis_dividend_tready,
  input  logic [DIVIDEND_WIDTH-1:0] s_axis_dividend_tdata,
  input  logic                      s_axis_divisor_tvalid,
  output logic                      s_axis_divisor_tready,
  input  logic [DIVISOR_WIDTH-1:0]  s_axis_divisor_tdata,
  output logic                      m_axis_dout_tvalid,
  input  logic                      m_axis_dout_tready,
  output logic [DOUT_WIDTH-1:0]     m_axis_dout_tdata,
  output logic                      m_axis_dout_tuser
);

  localparam int QW = DIVIDEND_WIDTH + FRACTION_WIDTH;
  localparam int RW = DIVISOR_WIDTH + 1;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);
  localparam logic [CW-1:0] CNT_FRAC = CW'(FRACTION_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [DIVIDEND_WIDTH-1:0] n_reg;
  logic [DIVISOR_WIDTH-1:0]  d_reg;
  logic [RW-1:0]             r_reg;
  logic [QW-1:0]             q_reg;
  logic [CW-1:0]             cnt;
  logic                      armed;

  logic          in_ready;
  logic          accept;
  logic          next_bit;
  logic          q_bit;
  logic [RW-1:0] d_ext;
  logic [RW-1:0] t_val;
  logic [RW-1:0] t_sub;

  // armed keeps the inputs blocked until the first edge after reset release
  assign in_ready = (state == IDLE) && armed;
  assign accept   = in_ready && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

  // Dividend bits feed the first DIVIDEND_WIDTH steps, zeros feed the fraction steps
  assign next_bit = (cnt >= CNT_FRAC) ? n_reg[DIVIDEND_WIDTH-1] : 1'b0;
  assign d_ext    = {1'b0, d_reg};
  assign t_val    = RW'({r_reg, next_bit});
  assign t_sub    = t_val - d_ext;
  assign q_bit    = (t_val >= d_ext);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (m_axis_dout_tready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      n_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      q_reg <= '0;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        n_reg <= s_axis_dividend_tdata;
        d_reg <= s_axis_divisor_tdata;
        r_reg <= '0;
        q_reg <= '0;
        cnt   <= CNT_LOAD;
      end else if (state == CALC) begin
        n_reg <= n_reg << 1;
        r_reg <= q_bit ? t_sub : t_val;
        q_reg <= {q_reg[QW-2:0], q_bit};
        cnt   <= cnt - CW'(1);
      end
    end
  end

  assign s_axis_dividend_tready = in_ready;
  assign s_axis_divisor_tready  = in_ready;
  assign m_axis_dout_tvalid     = (state == DONE);
  assign m_axis_dout_tdata      = DOUT_WIDTH'(q_reg);
  assign m_axis_dout_tuser      = (state == DONE) && (d_reg == '0);

endmodule

// File: tb/tb_radix2_divider.sv
// Directed and randomised checks of radix2_divider: results, latency, handshakes, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_radix2_divider;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        dividend_valid = 1'b0;
  logic        divisor_valid = 1'b0;
  logic        dout_ready = 1'b1;
  logic [12:0] dividend_data = '0;
  logic [12:0] divisor_data = '0;
  logic        dividend_ready;
  logic        divisor_ready;
  logic        dout_valid;
  logic        dout_user;
  logic [23:0] dout_data;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  radix2_divider dut (
    .i_clock                (i_clock),
    .i_reset_n              (i_reset_n),
    .s_axis_dividend_tvalid (dividend_valid),
    .s_axis_dividend_tready (dividend_ready),
    .s_axis_dividend_tdata  (dividend_data),
    .s_axis_divisor_tvalid  (divisor_valid),
    .s_axis_divisor_tready  (divisor_ready),
    .s_axis_divisor_tdata   (divisor_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tready     (dout_ready),
    .m_axis_dout_tdata      (dout_data),
    .m_axis_dout_tuser      (dout_user)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge with the DUT idle; returns at the falling edge after consumption.
  task automatic xfer(input logic [12:0] a, input logic [12:0] b, input int stall,
                      input bit throttle, output logic [23:0] data, output logic user,
                      output int lat, output int acc, output int held, output int k);
    int n;
    dividend_valid = 1'b1;
    dividend_data  = a;
    divisor_valid  = 1'b1;
    divisor_data   = b;
    if (stall > 0) dout_ready = 1'b0;
    n = 0;
    while (!(dividend_ready && divisor_ready) && n < 50) begin
      @(negedge i_clock);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    acc = cyc_cnt;
    @(negedge i_clock);
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    dividend_data  = '0;
    divisor_data   = '0;
    lat = 0;
    while (!dout_valid && lat < 100) begin
      if (throttle) dout_ready = 1'($urandom_range(0, 1));
      @(negedge i_clock);
      lat++;
    end
    chk("result_wait", 32'(dout_valid), 32'd1);
    data = dout_data;
    user = dout_user;
    held = 0;
    k = 0;
    while (dout_valid && k < 200) begin
      if (dout_data !== data || dout_user !== user || dividend_ready || divisor_ready) held++;
      if (stall > 0) dout_ready = (k >= stall);
      else if (throttle) dout_ready = 1'($urandom_range(0, 1));
      else dout_ready = 1'b1;
      @(negedge i_clock);
      k++;
    end
    dout_ready = 1'b1;
  endtask

  initial begin
    logic [23:0] data;
    logic        user;
    logic [12:0] a;
    logic [12:0] b;
    logic [31:0] exp_q;
    int lat, acc, held, k, prev_acc, bad;

    #12;
    chk("rst_tvalid", 32'(dout_valid), 32'd0);
    chk("rst_tdata", 32'(dout_data), 32'd0);
    chk("rst_tuser", 32'(dout_user), 32'd0);
    chk("rst_dividend_rdy", 32'(dividend_ready), 32'd0);
    chk("rst_divisor_rdy", 32'(divisor_ready), 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    #1;
    chk("rel_rdy_before_edge", 32'({dividend_ready, divisor_ready}), 32'd0);
    @(negedge i_clock);
    chk("rel_rdy_after_edge", 32'({dividend_ready, divisor_ready}), 32'd3);

    xfer(13'd100, 13'd50, 0, 1'b0, data, user, lat, acc, held, k);
    chk("int_data", 32'(data), 32'h000200);
    chk("int_user", 32'(user), 32'd0);
    chk("int_latency", 32'(lat), 32'd21);
    chk("int_single_xfer", 32'(k), 32'd1);
    prev_acc = acc;

    xfer(13'd1, 13'd3, 0, 1'b0, data, user, lat, acc, held, k);
    chk("frac_data", 32'(data), 32'h000055);
    chk("b2b_spacing", 32'(acc - prev_acc), 32'd23);
    prev_acc = acc;

    xfer(13'd8191, 13'd1, 0, 1'b0, data, user, lat, acc, held, k);
    chk("max_data", 32'(data), 32'h1FFF00);
    chk("max_user", 32'(user), 32'd0);
    chk("b2b_spacing2", 32'(acc - prev_acc), 32'd23);

    xfer(13'd5, 13'd0, 0, 1'b0, data, user, lat, acc, held, k);
    chk("dz_data", 32'(data), 32'h1FFFFF);
    chk("dz_user", 32'(user), 32'd1);
    chk("dz_latency", 32'(lat), 32'd21);

    // Dividend alone for 4 cycles must not start a division
    dividend_valid = 1'b1;
    dividend_data  = 13'd300;
    bad = 0;
    repeat (4) begin
      @(negedge i_clock);
      if (!(dividend_ready && divisor_ready) || dout_valid) bad++;
    end
    chk("lone_valid_waits", 32'(bad), 32'd0);
    xfer(13'd300, 13'd7, 10, 1'b0, data, user, lat, acc, held, k);
    chk("hs_data", 32'(data), 32'h002ADB);
    chk("hs_latency", 32'(lat), 32'd21);
    chk("stall_stable", 32'(held), 32'd0);
    chk("stall_release", 32'(k), 32'd11);
    chk("stall_rdy_after", 32'({dividend_ready, divisor_ready}), 32'd3);
    @(negedge i_clock);
    chk("stall_no_dup", 32'(dout_valid), 32'd0);

    prev_acc = -1;
    for (int i = 0; i < 50; i++) begin
      a = 13'($urandom_range(0, 8191));
      b = (i % 10 == 3) ? 13'd0 : 13'($urandom_range(1, 8191));
      exp_q = (b == 13'd0) ? 32'h1FFFFF : ((32'(a) * 32'd256) / 32'(b));
      xfer(a, b, 0, 1'b1, data, user, lat, acc, held, k);
      chk("rnd_data", 32'(data), exp_q);
      chk("rnd_user", 32'(user), 32'(b == 13'd0));
      chk("rnd_stable", 32'(held), 32'd0);
      if (prev_acc >= 0) chk("rnd_spacing_ge23", 32'((acc - prev_acc) >= 23), 32'd1);
      prev_acc = acc;
    end

    // Reset after 10 CALC steps abandons the division
    dividend_valid = 1'b1;
    dividend_data  = 13'd100;
    divisor_valid  = 1'b1;
    divisor_data   = 13'd50;
    @(negedge i_clock);
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    chk("calc_rdy_low", 32'({dividend_ready, divisor_ready}), 32'd0);
    repeat (10) @(negedge i_clock);
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(dout_valid), 32'd0);
    chk("mid_rst_tdata", 32'(dout_data), 32'd0);
    chk("mid_rst_rdy", 32'({dividend_ready, divisor_ready}), 32'd0);
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    #1;
    chk("mid_rel_rdy_before", 32'({dividend_ready, divisor_ready}), 32'd0);
    @(negedge i_clock);
    chk("mid_rel_rdy_after", 32'({dividend_ready, divisor_ready}), 32'd3);
    bad = 0;
    repeat (25) begin
      @(negedge i_clock);
      if (dout_valid) bad++;
    end
    chk("abandoned_no_result", 32'(bad), 32'd0);
    xfer(13'd7, 13'd2, 0, 1'b0, data, user, lat, acc, held, k);
    chk("post_rst_data", 32'(data), 32'h000380);
    chk("post_rst_user", 32'(user), 32'd0);
    chk("post_rst_latency", 32'(lat), 32'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
